mips_mem_access_unit: RTL and testbench
=======================================

// Module: mips_mem_access_unit
// PURPOSE
//  - Parametrised memory access unit between the multicycle MIPS core and the Avalon-MM bus.
//  - Serves instruction fetch, LB/LBU/LH/LHU/LW and SB/SH/SW requests one at a time.
//  - Generates byteenable/lane-shifted writedata, honours waitrequest, and sign/zero-extends loads.
//  - Flags misaligned accesses and, optionally, bus timeouts back to the core.
// PARAMETERS
//  ADDR_W          32   byte-address width; bus address always word-aligned (addr[1:0]=0)
//  TIMEOUT_CYCLES  64   waitrequest-stall limit, used only with MIPS_BUS_TIMEOUT_EN (>=1)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  req_valid     in   1       core request strobe
//  req_ready     out  1       =1 only in IDLE; request accepted when req_valid&req_ready
//  req_op        in   2       00 fetch, 01 load, 10 store, 11 reserved (treated as load)
//  req_size      in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  req_unsigned  in   1       load zero-extend (LBU/LHU); ignored for fetch/store/word
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, value in low bits
//  rsp_valid     out  1       one-cycle response pulse
//  rsp_rdata     out  32      extended load / fetch word; 0 for stores and errors
//  rsp_err       out  2       00 ok, 01 misaligned, 10 timeout; valid with rsp_valid
//  busy          out  1       =~req_ready
//  address       out  ADDR_W  Avalon address {req_addr[ADDR_W-1:2],2'b00}
//  read / write  out  1       Avalon read/write request, never both high
//  waitrequest   in   1       Avalon stall
//  writedata     out  32      lane-replicated store data
//  byteenable    out  4       active byte lanes
//  readdata      in   32      valid the cycle after read accepted (read & ~waitrequest)
// BEHAVIOUR
//  - Reset (async, low): state IDLE; address, writedata, rsp_rdata = 0; byteenable = 0;
//    read, write, rsp_valid = 0; rsp_err = 00. In-flight access dropped, no response.
//  - All outputs registered except req_ready/busy (decoded from state).
//  - FSM: IDLE -> RD_REQ|WR_REQ|RESP; RD_REQ -> RD_CAP; RD_CAP -> RESP; WR_REQ -> RESP; RESP -> IDLE.
//  - IDLE, accepting: misaligned (half & a[0]; word/fetch & a[1:0]!=0) -> RESP, rsp_err=01, no bus cycle.
//    Otherwise latch address/byteenable/writedata; load/fetch -> RD_REQ (read=1), store -> WR_REQ (write=1).
//  - RD_REQ/WR_REQ: read/write, address, byteenable, writedata held stable while waitrequest=1;
//    on waitrequest=0 drop read/write next edge. RD_REQ -> RD_CAP; WR_REQ -> RESP.
//  - RD_CAP: sample readdata, select lane, extend, register into rsp_rdata; -> RESP.
//  - RESP: rsp_valid=1 exactly one cycle, req_ready=0; next cycle IDLE. No back-to-back acceptance.
//  - Zero-wait latency from acceptance edge N: load/fetch rsp_valid at N+3, store at N+2,
//    misaligned at N+1. Each waitrequest cycle adds one.
//  - Lanes little-endian: byte k = data[8k+7:8k], k = a[1:0].
//    byteenable: byte 1<<k; half a[1]?1100:0011; word/fetch 1111.
//    writedata: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
//  - Load extend: byte/half sign-extend unless req_unsigned; fetch/word pass through.
//  - Request inputs are sampled only on acceptance; changes while busy are ignored.
// CONFIGURATION
//  MIPS_BUS_TIMEOUT_EN defined: stall counter cleared on entry to RD_REQ/WR_REQ, +1 per waitrequest=1 cycle.
//    When it reaches TIMEOUT_CYCLES: drop read/write next edge -> RESP with rsp_err=10, rsp_rdata=0.
//  Undefined: no counter; waits indefinitely; rsp_err never 10; TIMEOUT_CYCLES unused.
// TESTING
//  - Fetch 0xBFC00000, zero wait, readdata=0x2402000A -> read high 1 cycle,
//    rsp_valid at N+3, rsp_rdata=0x2402000A, err=00.
//  - LB addr 0x1003, readdata=0x80FF1234 -> byteenable=1000, rsp_rdata=0xFFFFFF80;
//    same with LBU -> 0x00000080; LH addr 0x1002 -> 0xFFFF80FF.
//  - SH addr 0x2002, wdata=0x0000BEEF, 3 waitrequest cycles -> write high 4 cycles,
//    be=1100, writedata=0xBEEFBEEF, address stable, rsp_valid at N+5.
//  - LW addr 0x3001 -> no read/write ever asserted, rsp_valid at N+1, rsp_err=01;
//    LH addr 0x3001 -> same.
//  - Reset low mid RD_REQ (waitrequest=1) -> read=0 immediately, no rsp_valid,
//    req_ready=1 after release, next LW completes normally.
//  - With MIPS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> read drops
//    after 4 stall cycles, rsp_err=10, rsp_rdata=0; without the macro, read held 100+ cycles, no rsp_valid.

Source files
------------

// File: rtl/mips_mem_access_unit.sv
// Memory access unit: MIPS core requests to Avalon-MM, one access at a time.
// Optional bus stall timeout enabled by defining MIPS_BUS_TIMEOUT_EN.
module mips_mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_CAP, WR_REQ, RESP
    } state_t;

    state_t state, state_nx;

    logic       accept;
    logic       is_store;
    logic [1:0] eff_size;
    logic       misaligned;
    logic [3:0] be_new;
    logic [31:0] wd_new;
    logic       in_req;
    logic       tmo_raw;
    logic       tmo_hit;

    logic [1:0] lane_q;
    logic [1:0] size_q;
    logic       uns_q;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready;
    assign is_store  = (req_op == 2'b10);
    assign in_req    = (state == RD_REQ) || (state == WR_REQ);
    assign tmo_hit   = in_req & tmo_raw;

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] stall_cnt;

    assign tmo_raw = waitrequest &&
                     (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count stalled bus cycles; restarts with every new bus request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (!in_req)
            stall_cnt <= '0;
        else if (waitrequest)
            stall_cnt <= stall_cnt + CW'(1);
    end
`else
    // No stall limit: the bus may hold waitrequest forever
    assign tmo_raw = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Request decode: effective size, alignment, lanes
    always_comb begin
        eff_size = req_size;
        if (req_op == 2'b00 || req_size == 2'b11)
            eff_size = 2'b10;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wd_new     = req_wdata;
        case (eff_size)
            2'b00: begin
                be_new = 4'b0001 << req_addr[1:0];
                wd_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be_new = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_new = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned = |req_addr[1:0];
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        ld_byte = readdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'b0, ld_byte}
                                    : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'b0, ld_half}
                                    : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = readdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)
                        state_nx = RESP;
                    else if (is_store)
                        state_nx = WR_REQ;
                    else
                        state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                if (tmo_hit)
                    state_nx = RESP;
                else if (!waitrequest)
                    state_nx = RD_CAP;
            end
            RD_CAP: state_nx = RESP;
            WR_REQ: begin
                if (tmo_hit || !waitrequest)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered bus and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 2'b00;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
        end else begin
            rsp_valid <= (state_nx == RESP);
            rsp_rdata <= (state == RD_CAP) ? ld_ext : 32'h0;
            rsp_err   <= 2'b00;
            read      <= (state == RD_REQ) & waitrequest & ~tmo_hit;
            write     <= (state == WR_REQ) & waitrequest & ~tmo_hit;
            if (tmo_hit)
                rsp_err <= 2'b10;
            if (accept) begin
                if (misaligned) begin
                    rsp_err <= 2'b01;
                end else begin
                    address    <= {req_addr[ADDR_W-1:2], 2'b00};
                    byteenable <= be_new;
                    writedata  <= wd_new;
                    lane_q     <= req_addr[1:0];
                    size_q     <= eff_size;
                    uns_q      <= req_unsigned;
                    read       <= ~is_store;
                    write      <= is_store;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Directed bench for mips_mem_access_unit with a small Avalon slave.
// Covers fetch, loads, stores, stalls, misalignment, reset and timeout.
module tb_mips_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int          total = 0;
    int          bad = 0;
    int          stall_cfg = 0;
    int          stalled = 0;
    logic [31:0] rd_word = 32'h0;

    int          lat;
    int          nrd;
    int          nwr;
    logic        stable;
    logic        seen;
    logic [31:0] g_rdata;
    logic [1:0]  g_err;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic        any_rsp;

    mips_mem_access_unit #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .address(address),
        .read(read),
        .write(write),
        .waitrequest(waitrequest),
        .writedata(writedata),
        .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    assign readdata    = rd_word;
    assign waitrequest = (read | write) && (stalled < stall_cfg);

    // Slave: count stalled cycles of the current bus request
    always @(posedge clk) begin
        if (!(read | write))
            stalled <= 0;
        else if (waitrequest)
            stalled <= stalled + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input int stalls,
                         input logic [31:0] rw, input int maxc);
        @(negedge clk);
        stall_cfg    = stalls;
        rd_word      = rw;
        req_op       = op;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_op       = ~op;
        req_size     = ~sz;
        req_unsigned = ~uns;
        req_addr     = ~a;
        req_wdata    = ~wd;
        lat = -1; nrd = 0; nwr = 0;
        stable = 1'b1; seen = 1'b0;
        g_rdata = 32'h0; g_err = 2'b00;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (read | write) begin
                if (read) nrd++;
                if (write) nwr++;
                if (read && write) stable = 1'b0;
                if (!seen) begin
                    cap_addr = address;
                    cap_be   = byteenable;
                    cap_wd   = writedata;
                    seen     = 1'b1;
                end else if (address != cap_addr ||
                             byteenable != cap_be ||
                             writedata != cap_wd) begin
                    stable = 1'b0;
                end
            end
            if (rsp_valid) begin
                lat     = k;
                g_rdata = rsp_rdata;
                g_err   = rsp_err;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdwr", {30'b0, read, write}, 32'd0);
        chk("rst_rsp", {29'b0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", {28'b0, byteenable}, 32'h0);
        chk("rst_wd", writedata, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;

        issue(2'b00, 2'b10, 1'b0, 32'hBFC00000, 32'h0, 0,
              32'h2402000A, 50);
        chk("fetch_lat", 32'(lat), 32'd3);
        chk("fetch_nrd", 32'(nrd), 32'd1);
        chk("fetch_nwr", 32'(nwr), 32'd0);
        chk("fetch_data", g_rdata, 32'h2402000A);
        chk("fetch_err", {30'b0, g_err}, 32'd0);
        chk("fetch_addr", cap_addr, 32'hBFC00000);
        chk("fetch_be", {28'b0, cap_be}, 32'hF);
        @(negedge clk);
        chk("pulse_once", {31'b0, rsp_valid}, 32'd0);
        chk("back_ready", {31'b0, req_ready}, 32'd1);

        issue(2'b01, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 32'h80FF1234, 50);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_be", {28'b0, cap_be}, 32'b1000);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_data", g_rdata, 32'hFFFFFF80);

        issue(2'b01, 2'b00, 1'b1, 32'h1003, 32'h0, 0, 32'h80FF1234, 50);
        chk("lbu_data", g_rdata, 32'h00000080);

        issue(2'b01, 2'b01, 1'b0, 32'h1002, 32'h0, 0, 32'h80FF1234, 50);
        chk("lh_be", {28'b0, cap_be}, 32'b1100);
        chk("lh_data", g_rdata, 32'hFFFF80FF);

        issue(2'b01, 2'b01, 1'b1, 32'h1000, 32'h0, 0, 32'h80FF1234, 50);
        chk("lhu_be", {28'b0, cap_be}, 32'b0011);
        chk("lhu_data", g_rdata, 32'h00001234);

        issue(2'b11, 2'b10, 1'b1, 32'h1004, 32'h0, 2, 32'h80FF1234, 50);
        chk("lw_lat", 32'(lat), 32'd5);
        chk("lw_data", g_rdata, 32'h80FF1234);

        issue(2'b10, 2'b01, 1'b0, 32'h2002, 32'h0000BEEF, 3,
              32'h0, 50);
        chk("sh_lat", 32'(lat), 32'd5);
        chk("sh_nwr", 32'(nwr), 32'd4);
        chk("sh_nrd", 32'(nrd), 32'd0);
        chk("sh_be", {28'b0, cap_be}, 32'b1100);
        chk("sh_wd", cap_wd, 32'hBEEFBEEF);
        chk("sh_addr", cap_addr, 32'h2000);
        chk("sh_stable", {31'b0, stable}, 32'd1);
        chk("sh_rdata", g_rdata, 32'h0);

        issue(2'b10, 2'b00, 1'b0, 32'h2001, 32'h12345678, 0, 32'h0, 50);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_be", {28'b0, cap_be}, 32'b0010);
        chk("sb_wd", cap_wd, 32'h78787878);

        issue(2'b10, 2'b11, 1'b0, 32'h2004, 32'hCAFEF00D, 0, 32'h0, 50);
        chk("sw_be", {28'b0, cap_be}, 32'hF);
        chk("sw_wd", cap_wd, 32'hCAFEF00D);

        issue(2'b01, 2'b10, 1'b0, 32'h3001, 32'h0, 0, 32'h0, 50);
        chk("mis_lw_lat", 32'(lat), 32'd1);
        chk("mis_lw_bus", 32'(nrd + nwr), 32'd0);
        chk("mis_lw_err", {30'b0, g_err}, 32'd1);
        chk("mis_lw_data", g_rdata, 32'h0);

        issue(2'b01, 2'b01, 1'b0, 32'h3001, 32'h0, 0, 32'h0, 50);
        chk("mis_lh_lat", 32'(lat), 32'd1);
        chk("mis_lh_bus", 32'(nrd + nwr), 32'd0);
        chk("mis_lh_err", {30'b0, g_err}, 32'd1);

        issue(2'b00, 2'b00, 1'b0, 32'h3002, 32'h0, 0, 32'h0, 50);
        chk("mis_fetch_err", {30'b0, g_err}, 32'd1);

        issue(2'b01, 2'b10, 1'b0, 32'h4000, 32'h0, 1000, 32'h0, 3);
        chk("rstmid_busy", 32'(nrd), 32'd3);
        reset = 1'b0;
        #1;
        chk("rstmid_read", {31'b0, read}, 32'd0);
        chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        any_rsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_rsp = any_rsp | rsp_valid;
        end
        chk("rstmid_norsp", {31'b0, any_rsp}, 32'd0);
        chk("rstmid_ready2", {31'b0, req_ready}, 32'd1);
        issue(2'b01, 2'b10, 1'b0, 32'h4000, 32'h0, 0, 32'h11223344, 50);
        chk("after_rst_lat", 32'(lat), 32'd3);
        chk("after_rst_data", g_rdata, 32'h11223344);

`ifdef MIPS_BUS_TIMEOUT_EN
        issue(2'b01, 2'b10, 1'b0, 32'h5000, 32'h0, 1000, 32'hFFFFFFFF, 50);
        chk("tmo_lat", 32'(lat), 32'd5);
        chk("tmo_nrd", 32'(nrd), 32'd4);
        chk("tmo_err", {30'b0, g_err}, 32'd2);
        chk("tmo_data", g_rdata, 32'h0);
        @(negedge clk);
        chk("tmo_idle", {30'b0, read, write}, 32'd0);
`else
        issue(2'b01, 2'b10, 1'b0, 32'h5000, 32'h0, 1000, 32'hFFFFFFFF, 110);
        chk("stuck_norsp", 32'(lat), 32'hFFFFFFFF);
        chk("stuck_nrd", 32'(nrd), 32'd110);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("stuck_recover", {31'b0, req_ready}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
